// File: rtl/ntt_result_packer_pkg.sv
// Shared NTT definitions: result-packer FSM states, packing defaults and the ML-DSA modulus.
package ntt_result_packer_pkg;

  // Default packing geometry: 4 coefficients per word, 64 words per 256-coefficient polynomial
  localparam int DEF_COEFF_PER_WORD = 4;
  localparam int DEF_WORDS_PER_POLY = 64;

  // ML-DSA prime q = 2^23 - 2^13 + 1; coefficients arriving at the packer are already below it
  localparam int MLDSA_Q = 8380417;

  // Packer control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } packer_state_e;

endpackage

// File: rtl/ntt_result_packer.sv
// Packs reduced NTT coefficients, COEFF_PER_WORD at a time, into polynomial memory words.
// Lane 0 lands in the LSBs; word k of the polynomial is written at base + k (mod 2^ADDR_WIDTH).
module ntt_result_packer
  import ntt_result_packer_pkg::*;
#(
  parameter int REG_SIZE       = 24,
  parameter int COEFF_PER_WORD = DEF_COEFF_PER_WORD,
  parameter int WORDS_PER_POLY = DEF_WORDS_PER_POLY,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               zeroize,
  input  logic                               start_i,
  input  logic [ADDR_WIDTH-1:0]              base_addr_i,
  input  logic                               valid_i,
  input  logic [REG_SIZE-1:0]                res_i,
  output logic                               mem_we_o,
  output logic [ADDR_WIDTH-1:0]              mem_waddr_o,
  output logic [COEFF_PER_WORD*REG_SIZE-1:0] mem_wdata_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam int DATA_W        = COEFF_PER_WORD * REG_SIZE;
  localparam int NUM_LANE_REGS = COEFF_PER_WORD - 1;
  localparam int LANE_W        = (COEFF_PER_WORD > 1) ? $clog2(COEFF_PER_WORD) : 1;
  localparam int WORD_W        = (WORDS_PER_POLY > 1) ? $clog2(WORDS_PER_POLY) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(COEFF_PER_WORD - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_POLY - 1);

  packer_state_e state_q, state_d;

  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [REG_SIZE-1:0]   lane_q [NUM_LANE_REGS];
  logic [REG_SIZE-1:0]   lane_d [NUM_LANE_REGS];

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic last_lane;

  assign last_lane = (lane_cnt_q == LAST_LANE);

  // Next-state logic: zeroize beats start, start beats any valid, then per-state behaviour
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    word_cnt_d = word_cnt_q;
    base_d     = base_q;
    lane_d     = lane_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (zeroize) begin
      state_d    = IDLE;
      lane_cnt_d = '0;
      word_cnt_d = '0;
      base_d     = '0;
      for (int k = 0; k < NUM_LANE_REGS; k++) lane_d[k] = '0;
      waddr_d    = '0;
      wdata_d    = '0;
      err_d      = 1'b0;
    end else if (start_i) begin
      state_d    = COLLECT;
      lane_cnt_d = '0;
      word_cnt_d = '0;
      base_d     = base_addr_i;
      for (int k = 0; k < NUM_LANE_REGS; k++) lane_d[k] = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) err_d = 1'b1;
        end
        COLLECT: begin
          if (valid_i) begin
            for (int k = 0; k < NUM_LANE_REGS; k++) begin
              if (lane_cnt_q == LANE_W'(k)) lane_d[k] = res_i;
            end
            if (last_lane) begin
              we_d    = 1'b1;
              waddr_d = base_q + ADDR_WIDTH'(word_cnt_q);
              for (int k = 0; k < NUM_LANE_REGS; k++) begin
                wdata_d[k*REG_SIZE +: REG_SIZE] = lane_q[k];
              end
              wdata_d[NUM_LANE_REGS*REG_SIZE +: REG_SIZE] = res_i;
              lane_cnt_d = '0;
              word_cnt_d = word_cnt_q + WORD_W'(1);
              if (word_cnt_q == LAST_WORD) state_d = DONE;
            end else begin
              lane_cnt_d = lane_cnt_q + LANE_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (valid_i) err_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters, lane storage and registered memory-port outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      word_cnt_q <= '0;
      base_q     <= '0;
      for (int k = 0; k < NUM_LANE_REGS; k++) lane_q[k] <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      word_cnt_q <= word_cnt_d;
      base_q     <= base_d;
      lane_q     <= lane_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ntt_result_packer.sv
// Self-checking bench for ntt_result_packer: a fixed vector table, then long streams
// checked cycle by cycle against a queue-based model of the packing rules.
module tb_ntt_result_packer;

  localparam int RS  = 24;
  localparam int CPW = 4;
  localparam int WPP = 64;
  localparam int AW  = 10;
  localparam int DW  = CPW * RS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          zeroize;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic          valid_i;
  logic [RS-1:0] res_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_waddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  ntt_result_packer #(
    .REG_SIZE(RS), .COEFF_PER_WORD(CPW), .WORDS_PER_POLY(WPP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
    .base_addr_i(base_addr_i), .valid_i(valid_i), .res_i(res_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int lastDoneCycle = -1;

  // Model: polynomial in progress, coefficients awaiting a full word, expected outputs
  bit            mCollect, mFinal, mErr, mWe, mDone;
  logic [AW-1:0] mBase, mAddr;
  logic [DW-1:0] mData;
  int            mWords;
  logic [RS-1:0] mCoeffs[$];

  logic [AW-1:0] wrAddr[$];
  logic [DW-1:0] wrData[$];
  logic [AW-1:0] aAddr[$];
  logic [DW-1:0] aData[$];

  typedef struct {
    bit            z, st, v;
    logic [AW-1:0] b;
    logic [RS-1:0] r;
    bit            eWe, eBusy, eErr, eDone;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
  } vec_t;
  vec_t vecs[$];

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mCollect = 0; mFinal = 0; mErr = 0; mWe = 0; mDone = 0;
    mBase = '0; mAddr = '0; mData = '0; mWords = 0;
    mCoeffs.delete();
  endfunction

  function automatic void modelStep(bit z, bit st, logic [AW-1:0] b, bit v, logic [RS-1:0] r);
    mWe = 0; mDone = 0;
    if (z) begin
      modelReset();
    end else if (st) begin
      mCollect = 1; mFinal = 0; mErr = 0; mWords = 0; mBase = b;
      mCoeffs.delete();
    end else if (mFinal) begin
      mFinal = 0; mDone = 1;
      if (v) mErr = 1;
    end else if (mCollect) begin
      if (v) begin
        mCoeffs.push_back(r);
        if (mCoeffs.size() == CPW) begin
          mWe   = 1;
          mAddr = AW'((int'(mBase) + mWords) % (1 << AW));
          for (int k = 0; k < CPW; k++) mData[k*RS +: RS] = mCoeffs[k];
          mCoeffs.delete();
          mWords++;
          if (mWords == WPP) begin
            mCollect = 0; mFinal = 1;
          end
        end
      end
    end else if (v) begin
      mErr = 1;
    end
  endfunction

  task automatic checkOutput(input string tag);
    checkVal({tag, ".we"},    DW'(mem_we_o),    DW'(mWe));
    checkVal({tag, ".waddr"}, DW'(mem_waddr_o), DW'(mAddr));
    checkVal({tag, ".wdata"}, mem_wdata_o,      mData);
    checkVal({tag, ".busy"},  DW'(busy_o),      DW'(mCollect || mFinal));
    checkVal({tag, ".done"},  DW'(done_o),      DW'(mDone));
    checkVal({tag, ".err"},   DW'(err_o),       DW'(mErr));
  endtask

  // Drive one cycle of inputs, advance the clock, then compare against the model
  task automatic applyStimulus(input bit z, input bit st, input logic [AW-1:0] b,
                               input bit v, input logic [RS-1:0] r);
    zeroize = z; start_i = st; base_addr_i = b; valid_i = v; res_i = r;
    modelStep(z, st, b, v, r);
    @(posedge clk); #1;
    cycle++;
    zeroize = 0; start_i = 0; valid_i = 0;
    if (mem_we_o === 1'b1) begin
      wrAddr.push_back(mem_waddr_o);
      wrData.push_back(mem_wdata_o);
    end
    if (done_o === 1'b1) lastDoneCycle = cycle;
    checkOutput($sformatf("cyc%0d", cycle));
  endtask

  task automatic addVec(bit z, bit st, logic [AW-1:0] b, bit v, logic [RS-1:0] r,
                        bit eWe, bit eBusy, bit eErr, bit eDone,
                        logic [AW-1:0] eAddr, logic [DW-1:0] eData);
    vec_t t;
    t.z = z; t.st = st; t.b = b; t.v = v; t.r = r;
    t.eWe = eWe; t.eBusy = eBusy; t.eErr = eErr; t.eDone = eDone;
    t.eAddr = eAddr; t.eData = eData;
    vecs.push_back(t);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] d1, expWord;
    int startCyc, n;
    bit v;
    logic [RS-1:0] r;

    d1 = {24'd4, 24'd3, 24'd2, 24'd1};

    addVec(0,0,10'h000,0,24'd0, 0,0,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd9, 0,0,1,0, 10'h000, '0);
    addVec(0,0,10'h000,0,24'd0, 0,0,1,0, 10'h000, '0);
    addVec(0,1,10'h005,0,24'd0, 0,1,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd1, 0,1,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd2, 0,1,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd3, 0,1,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd4, 1,1,0,0, 10'h005, d1);
    addVec(0,0,10'h000,0,24'd0, 0,1,0,0, 10'h005, d1);
    addVec(1,0,10'h000,0,24'd0, 0,0,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd5, 0,0,1,0, 10'h000, '0);
    addVec(1,0,10'h000,1,24'd5, 0,0,0,0, 10'h000, '0);
    addVec(0,1,10'h003,1,24'd6, 0,1,0,0, 10'h000, '0);
    addVec(0,0,10'h000,1,24'd7, 0,1,0,0, 10'h000, '0);
    addVec(1,0,10'h000,0,24'd0, 0,0,0,0, 10'h000, '0);

    reset_n = 0; zeroize = 0; start_i = 0; base_addr_i = '0; valid_i = 0; res_i = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    reset_n = 1;

    // Vector table: idle error, first word, zeroize priority, start beating valid
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].z, vecs[i].st, vecs[i].b, vecs[i].v, vecs[i].r);
      checkVal($sformatf("vec%0d.we", i),    DW'(mem_we_o),    DW'(vecs[i].eWe));
      checkVal($sformatf("vec%0d.busy", i),  DW'(busy_o),      DW'(vecs[i].eBusy));
      checkVal($sformatf("vec%0d.err", i),   DW'(err_o),       DW'(vecs[i].eErr));
      checkVal($sformatf("vec%0d.done", i),  DW'(done_o),      DW'(vecs[i].eDone));
      checkVal($sformatf("vec%0d.waddr", i), DW'(mem_waddr_o), DW'(vecs[i].eAddr));
      checkVal($sformatf("vec%0d.wdata", i), mem_wdata_o,      vecs[i].eData);
    end

    // Full polynomial, back-to-back valids, res = i
    wrAddr.delete(); wrData.delete();
    startCyc = cycle;
    applyStimulus(0, 1, 10'h010, 0, '0);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, '0, 1, RS'(i));
    applyStimulus(0, 0, '0, 0, '0);
    checkVal("a.doneLatency", DW'(lastDoneCycle - startCyc), DW'(258));
    checkVal("a.writeCount", DW'(wrAddr.size()), DW'(64));
    checkVal("a.firstWord", (wrData.size() > 0) ? wrData[0] : '0,
             {24'd3, 24'd2, 24'd1, 24'd0});
    for (int k = 0; k < wrAddr.size(); k++) begin
      expWord = {RS'(4*k+3), RS'(4*k+2), RS'(4*k+1), RS'(4*k)};
      checkVal($sformatf("a.addr%0d", k), DW'(wrAddr[k]), DW'(16 + k));
      checkVal($sformatf("a.data%0d", k), wrData[k], expWord);
    end
    aAddr = wrAddr; aData = wrData;

    // Same stream with valid every 3rd cycle, then valids in the DONE cycle and in IDLE
    wrAddr.delete(); wrData.delete();
    applyStimulus(0, 1, 10'h010, 0, '0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 0, '0, 0, '0);
      applyStimulus(0, 0, '0, 0, '0);
      applyStimulus(0, 0, '0, 1, RS'(i));
    end
    applyStimulus(0, 0, '0, 1, 24'h123);
    checkVal("b.doneCycleErr", DW'(err_o), DW'(1));
    checkVal("b.doneCycleDone", DW'(done_o), DW'(1));
    applyStimulus(0, 0, '0, 0, '0);
    checkVal("b.errHeld", DW'(err_o), DW'(1));
    applyStimulus(0, 0, '0, 1, 24'h456);
    checkVal("b.idleValidNoWrite", DW'(mem_we_o), DW'(0));
    checkVal("b.writeCount", DW'(wrAddr.size()), DW'(aAddr.size()));
    for (int k = 0; k < wrAddr.size() && k < aAddr.size(); k++) begin
      checkVal($sformatf("b.sameAddr%0d", k), DW'(wrAddr[k]), DW'(aAddr[k]));
      checkVal($sformatf("b.sameData%0d", k), wrData[k], aData[k]);
    end

    // Wrapping base with random data and random gaps
    wrAddr.delete(); wrData.delete();
    applyStimulus(0, 1, 10'h3F0, 0, '0);
    checkVal("c.errClearedByStart", DW'(err_o), DW'(0));
    n = 0;
    while (n < 256) begin
      v = ($urandom_range(0, 9) < 7);
      r = RS'($urandom % ntt_result_packer_pkg::MLDSA_Q);
      applyStimulus(0, 0, '0, v, r);
      if (v) n++;
    end
    applyStimulus(0, 0, '0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0);
    checkVal("c.writeCount", DW'(wrAddr.size()), DW'(64));
    for (int k = 0; k < wrAddr.size(); k++) begin
      checkVal($sformatf("c.addr%0d", k), DW'(wrAddr[k]), DW'((16'h3F0 + k) % 1024));
    end
    checkVal("c.noErr", DW'(err_o), DW'(0));

    // Restart mid-word: old lone word still written, leftovers discarded
    wrAddr.delete(); wrData.delete();
    applyStimulus(0, 1, 10'h200, 0, '0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, 1, RS'($urandom % ntt_result_packer_pkg::MLDSA_Q));
    applyStimulus(0, 1, 10'h100, 0, '0);
    applyStimulus(0, 0, '0, 1, 24'h0A0A0A);
    applyStimulus(0, 0, '0, 1, 24'h0B0B0B);
    applyStimulus(0, 0, '0, 1, 24'h0C0C0C);
    applyStimulus(0, 0, '0, 1, 24'h0D0D0D);
    applyStimulus(0, 0, '0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0);
    checkVal("d.writeCount", DW'(wrAddr.size()), DW'(2));
    checkVal("d.oldAddr", (wrAddr.size() > 0) ? DW'(wrAddr[0]) : '1, DW'(10'h200));
    checkVal("d.newAddr", (wrAddr.size() > 1) ? DW'(wrAddr[1]) : '1, DW'(10'h100));
    checkVal("d.newData", (wrData.size() > 1) ? wrData[1] : '1,
             {24'h0D0D0D, 24'h0C0C0C, 24'h0B0B0B, 24'h0A0A0A});
    checkVal("d.stillBusy", DW'(busy_o), DW'(1));

    // Asynchronous reset while the fourth valid of a word is being presented
    applyStimulus(0, 1, 10'h050, 0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, RS'(i + 100));
    valid_i = 1; res_i = 24'd103;
    #3;
    reset_n = 0;
    modelReset();
    #1;
    checkOutput("asyncReset");
    @(posedge clk); #1;
    cycle++;
    valid_i = 0;
    checkOutput("inReset");
    reset_n = 1;
    applyStimulus(0, 0, '0, 0, '0);
    checkVal("f.noWriteAfterReset", DW'(mem_we_o), DW'(0));
    checkVal("f.idleAfterReset", DW'(busy_o), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
